// File: rtl/a2d_sched.sv
// Round-robin scheduler that drives the shared SPI master through the two-frame
// ADC128S protocol for the load cells, steering pot and battery channels.
module a2d_sched #(
  parameter logic [2:0] CH_LFT   = 3'd0,
  parameter logic [2:0] CH_RGHT  = 3'd4,
  parameter logic [2:0] CH_STEER = 3'd5,
  parameter logic [2:0] CH_BATT  = 3'd6,
  parameter int         TMO_CYC  = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        vld,
  output logic [1:0]  vld_ch,
  output logic        tmo_err
);

  localparam int CW = (($clog2(TMO_CYC) + 1) > 12) ? ($clog2(TMO_CYC) + 1) : 12;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

  typedef enum logic [1:0] {IDLE, ADDR, GAP, READ} state_t;

  state_t          state, state_d;
  logic [1:0]      rr;
  logic            pend;
  logic [CW-1:0]   wait_cnt;
  logic [2:0]      chnl;
  logic            trig, launch, wrt_d, capture, timeout, tmo_hit;
  logic            unused_rd_hi;

  assign trig         = nxt | pend;
  assign tmo_hit      = (wait_cnt == TMO_LAST);
  assign unused_rd_hi = ^rd_data[15:12];

  always_comb begin
    case (rr)
      2'd0:    chnl = CH_LFT;
      2'd1:    chnl = CH_RGHT;
      2'd2:    chnl = CH_STEER;
      default: chnl = CH_BATT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // done outranks a simultaneous timeout so a late-but-valid frame is kept
  always_comb begin
    state_d = state;
    launch  = 1'b0;
    wrt_d   = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          launch  = 1'b1;
          wrt_d   = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (done) begin
          state_d = GAP;
        end else if (tmo_hit) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: begin
        wrt_d   = 1'b1;
        state_d = READ;
      end
      READ: begin
        if (done) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrt       <= 1'b0;
      cmd       <= {2'b00, CH_LFT, 11'h000};
      rr        <= 2'd0;
      pend      <= 1'b0;
      wait_cnt  <= '0;
      vld       <= 1'b0;
      vld_ch    <= 2'd0;
      tmo_err   <= 1'b0;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'hFFF;
    end else begin
      wrt <= wrt_d;
      cmd <= {2'b00, chnl, 11'h000};
      vld <= capture;

      if (launch)   pend <= 1'b0;
      else if (nxt) pend <= 1'b1;

      if (wrt_d)
        wait_cnt <= '0;
      else if (state == ADDR || state == READ)
        wait_cnt <= wait_cnt + 1'b1;

      if (timeout) tmo_err <= 1'b1;

      if (capture) begin
        vld_ch <= rr;
        rr     <= rr + 1'b1;
        case (rr)
          2'd0:    lft_ld    <= rd_data[11:0];
          2'd1:    rght_ld   <= rd_data[11:0];
          2'd2:    steer_pot <= rd_data[11:0];
          default: batt      <= rd_data[11:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_a2d_sched.sv
// Directed self-checking bench for a2d_sched with a behavioural ADC128S/SPI model
// that answers each frame with the channel addressed in the previous frame.
module tb_a2d_sched;

  localparam int T_SPI = 5;
  localparam int TMO   = 2048;
  localparam logic [15:0] RR_CMD  [4] = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
  localparam logic [11:0] RR_DATA [4] = '{12'h0AB, 12'h8AB, 12'hAAB, 12'hCAB};
  localparam logic [11:0] FS_DATA [4] = '{12'h350, 12'h340, 12'h800, 12'hC00};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nxt = 1'b0;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        vld;
  logic [1:0]  vld_ch;
  logic        tmo_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wrt_cnt = 0;
  int vld_cnt = 0;
  logic [15:0] wrt_log[$];
  int          wrt_cyc_log[$];
  int          vld_cyc_log[$];
  logic [1:0]  vld_ch_log[$];

  bit          spi_mute   = 1'b0;
  bit          spi_analog = 1'b0;
  logic [8:0]  echo_lo    = 9'h0AB;
  logic [2:0]  prev_ch    = 3'd7;
  logic [2:0]  spi_cur;

  a2d_sched dut (
    .clk(clk), .rst(rst), .nxt(nxt), .wrt(wrt), .cmd(cmd), .done(done),
    .rd_data(rd_data), .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot),
    .batt(batt), .vld(vld), .vld_ch(vld_ch), .tmo_err(tmo_err)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] adc_resp(input logic [2:0] ch);
    if (spi_analog) begin
      case (ch)
        3'd0:    return {4'h0, 12'h350};
        3'd4:    return {4'h0, 12'h340};
        3'd5:    return {4'h0, 12'h800};
        3'd6:    return {4'h0, 12'hC00};
        default: return 16'h0000;
      endcase
    end
    return {4'h0, ch, echo_lo};
  endfunction

  function automatic logic [11:0] slot_reg(input int s);
    case (s)
      0:       return lft_ld;
      1:       return rght_ld;
      2:       return steer_pot;
      default: return batt;
    endcase
  endfunction

  // SPI master + ADC model: done comes T_SPI cycles after wrt
  initial begin
    done    = 1'b0;
    rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (wrt && !spi_mute) begin
        spi_cur = cmd[13:11];
        repeat (T_SPI) @(negedge clk);
        rd_data = adc_resp(prev_ch);
        prev_ch = spi_cur;
        done    = 1'b1;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (wrt) begin
      wrt_cnt++;
      wrt_log.push_back(cmd);
      wrt_cyc_log.push_back(cyc);
    end
    if (vld) begin
      vld_cnt++;
      vld_cyc_log.push_back(cyc);
      vld_ch_log.push_back(vld_ch);
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_logs();
    wrt_log.delete();
    wrt_cyc_log.delete();
    vld_cyc_log.delete();
    vld_ch_log.delete();
  endtask

  task automatic pulse_nxt(output int at_cyc);
    @(negedge clk);
    nxt    = 1'b1;
    at_cyc = cyc;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  task automatic wait_vld(input int target, output bit ok);
    for (int i = 0; i < 400; i++) begin
      if (vld_cnt >= target) break;
      @(negedge clk);
    end
    ok = (vld_cnt >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nxt = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wrt, vld, vld_ch, tmo_err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: wrt/vld/vld_ch/tmo_err got %b expected 00000", {wrt, vld, vld_ch, tmo_err});
    end
    checks++;
    if ({lft_ld, rght_ld, steer_pot, batt} !== {12'h000, 12'h000, 12'h000, 12'hFFF}) begin
      errors++;
      $display("[TB] FAIL reset_regs: got %h %h %h %h expected 000 000 000 fff", lft_ld, rght_ld, steer_pot, batt);
    end
    checks++;
    if (cmd !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_cmd: got %h expected 0000", cmd);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wrt_cnt != 0 || wrt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_wrt: wrt pulses %0d expected 0", wrt_cnt);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int tgt;
    bit ok;
    spi_analog = 1'b0;
    echo_lo    = 9'h0AB;
    for (int i = 0; i < 4; i++) begin
      clear_logs();
      tgt = vld_cnt + 1;
      pulse_nxt(n);
      wait_vld(tgt, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL rr_vld_timeout slot %0d: vld count %0d expected %0d", i, vld_cnt, tgt);
      end
      checks++;
      if (wrt_log.size() != 2 || wrt_log[0] !== RR_CMD[i] || wrt_log[1] !== RR_CMD[i]) begin
        errors++;
        $display("[TB] FAIL rr_cmd slot %0d: %0d frames, first %h expected 2 frames of %h", i,
                 wrt_log.size(), (wrt_log.size() > 0) ? wrt_log[0] : 16'hxxxx, RR_CMD[i]);
      end
      checks++;
      if (vld_ch_log.size() != 1 || vld_ch_log[0] !== 2'(i)) begin
        errors++;
        $display("[TB] FAIL rr_vld_ch slot %0d: got %0d (count %0d) expected %0d", i,
                 (vld_ch_log.size() > 0) ? vld_ch_log[0] : 2'bxx, vld_ch_log.size(), i);
      end
      checks++;
      if (slot_reg(i) !== RR_DATA[i]) begin
        errors++;
        $display("[TB] FAIL rr_data slot %0d: got %h expected %h", i, slot_reg(i), RR_DATA[i]);
      end
      checks++;
      if (vld_cyc_log.size() != 1 || wrt_cyc_log.size() != 2 ||
          wrt_cyc_log[0] - n != 1 || wrt_cyc_log[1] - wrt_cyc_log[0] != T_SPI + 2 ||
          vld_cyc_log[0] - n != 2 * T_SPI + 4) begin
        errors++;
        $display("[TB] FAIL rr_latency slot %0d: vld-trig %0d expected %0d", i,
                 (vld_cyc_log.size() > 0) ? vld_cyc_log[0] - n : -1, 2 * T_SPI + 4);
      end
    end
    checks++;
    if ({lft_ld, rght_ld, steer_pot, batt} !== {RR_DATA[0], RR_DATA[1], RR_DATA[2], RR_DATA[3]}) begin
      errors++;
      $display("[TB] FAIL rr_all_regs: got %h %h %h %h expected 0ab 8ab aab cab", lft_ld, rght_ld, steer_pot, batt);
    end
  endtask

  task automatic test_wrap();
    int n;
    int tgt;
    bit ok;
    echo_lo = 9'h055;
    clear_logs();
    tgt = vld_cnt + 1;
    pulse_nxt(n);
    wait_vld(tgt, ok);
    checks++;
    if (!ok || wrt_log.size() != 2 || wrt_log[0] !== 16'h0000 || wrt_log[1] !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL wrap_cmd: %0d frames, first %h expected 2 frames of 0000",
               wrt_log.size(), (wrt_log.size() > 0) ? wrt_log[0] : 16'hxxxx);
    end
    checks++;
    if (vld_ch_log.size() != 1 || vld_ch_log[0] !== 2'd0) begin
      errors++;
      $display("[TB] FAIL wrap_vld_ch: got %0d expected 0", (vld_ch_log.size() > 0) ? vld_ch_log[0] : 2'bxx);
    end
    checks++;
    if ({lft_ld, rght_ld, steer_pot, batt} !== {12'h055, 12'h8AB, 12'hAAB, 12'hCAB}) begin
      errors++;
      $display("[TB] FAIL wrap_regs: got %h %h %h %h expected 055 8ab aab cab", lft_ld, rght_ld, steer_pot, batt);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int w0;
    int v0;
    bit ok;
    echo_lo = 9'h0CD;
    clear_logs();
    w0 = wrt_cnt;
    v0 = vld_cnt;
    pulse_nxt(n);
    for (int k = 0; k < 3; k++) begin
      nxt = 1'b1;
      @(negedge clk);
      nxt = 1'b0;
      @(negedge clk);
    end
    wait_vld(v0 + 2, ok);
    repeat (50) @(negedge clk);
    checks++;
    if (vld_cnt != v0 + 2 || wrt_cnt != w0 + 4) begin
      errors++;
      $display("[TB] FAIL pend_collapse: conversions %0d wrt %0d expected 2 and 4", vld_cnt - v0, wrt_cnt - w0);
    end
    checks++;
    if (wrt_cyc_log.size() < 3 || vld_cyc_log.size() < 1 || wrt_cyc_log[2] != vld_cyc_log[0] + 1) begin
      errors++;
      $display("[TB] FAIL pend_b2b_gap: second launch at %0d expected %0d",
               (wrt_cyc_log.size() > 2) ? wrt_cyc_log[2] : -1, (vld_cyc_log.size() > 0) ? vld_cyc_log[0] + 1 : -1);
    end
    checks++;
    if (vld_ch_log.size() != 2 || vld_ch_log[0] !== 2'd1 || vld_ch_log[1] !== 2'd2) begin
      errors++;
      $display("[TB] FAIL pend_slots: %0d results, first %0d expected slots 1 then 2",
               vld_ch_log.size(), (vld_ch_log.size() > 0) ? vld_ch_log[0] : 2'bxx);
    end
    checks++;
    if ({rght_ld, steer_pot} !== {12'h8CD, 12'hACD}) begin
      errors++;
      $display("[TB] FAIL pend_data: got %h %h expected 8cd acd", rght_ld, steer_pot);
    end
  endtask

  task automatic test_timeout();
    int n;
    int w0;
    int v0;
    int wc;
    bit ok;
    spi_mute = 1'b1;
    clear_logs();
    w0 = wrt_cnt;
    v0 = vld_cnt;
    pulse_nxt(n);
    wc = (wrt_cyc_log.size() > 0) ? wrt_cyc_log[0] : n + 1;
    for (int i = 0; i < 3000 && cyc < wc + TMO - 1; i++) @(negedge clk);
    checks++;
    if (tmo_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tmo_early: tmo_err %b one cycle before limit expected 0", tmo_err);
    end
    @(negedge clk);
    checks++;
    if (tmo_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tmo_set: tmo_err %b at cycle %0d after wrt expected 1", tmo_err, cyc - wc);
    end
    spi_mute = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (vld_cnt != v0 || wrt_cnt != w0 + 1) begin
      errors++;
      $display("[TB] FAIL tmo_quiet: vld %0d wrt %0d expected 0 and 1", vld_cnt - v0, wrt_cnt - w0);
    end
    echo_lo = 9'h033;
    clear_logs();
    pulse_nxt(n);
    wait_vld(v0 + 1, ok);
    checks++;
    if (!ok || wrt_log.size() != 2 || wrt_log[0] !== 16'h3000 || wrt_log[1] !== 16'h3000 ||
        wrt_cyc_log[0] != n + 1) begin
      errors++;
      $display("[TB] FAIL tmo_retry_cmd: first %h expected 3000 launched one cycle after trigger",
               (wrt_log.size() > 0) ? wrt_log[0] : 16'hxxxx);
    end
    checks++;
    if (vld_ch_log.size() != 1 || vld_ch_log[0] !== 2'd3 || batt !== 12'hC33 || tmo_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tmo_retry_result: batt %h tmo_err %b expected c33 and sticky 1", batt, tmo_err);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    int w0;
    int v0;
    w0 = wrt_cnt;
    pulse_nxt(n);
    for (int i = 0; i < 100 && wrt_cnt < w0 + 2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (wrt_cnt != w0 + 2) begin
      errors++;
      $display("[TB] FAIL mid_read_reach: wrt pulses %0d expected 2 before reset", wrt_cnt - w0);
    end
    checks++;
    if ({wrt, vld, tmo_err, cmd} !== 19'b0) begin
      errors++;
      $display("[TB] FAIL mid_read_ctrl: wrt %b vld %b tmo_err %b cmd %h expected 0 0 0 0000", wrt, vld, tmo_err, cmd);
    end
    checks++;
    if ({lft_ld, rght_ld, steer_pot, batt} !== {12'h000, 12'h000, 12'h000, 12'hFFF}) begin
      errors++;
      $display("[TB] FAIL mid_read_regs: got %h %h %h %h expected 000 000 000 fff", lft_ld, rght_ld, steer_pot, batt);
    end
    v0 = vld_cnt;
    w0 = wrt_cnt;
    repeat (30) @(negedge clk);
    checks++;
    if (vld_cnt != v0 || wrt_cnt != w0) begin
      errors++;
      $display("[TB] FAIL stale_done: vld %0d wrt %0d after reset expected 0 and 0", vld_cnt - v0, wrt_cnt - w0);
    end
  endtask

  task automatic test_full_system();
    int n;
    int tgt;
    bit ok;
    spi_analog = 1'b1;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      tgt = vld_cnt + 1;
      pulse_nxt(n);
      wait_vld(tgt, ok);
      checks++;
      if (!ok || slot_reg(i) !== FS_DATA[i]) begin
        errors++;
        $display("[TB] FAIL fs_slot %0d: got %h expected %h", i, slot_reg(i), FS_DATA[i]);
      end
    end
    checks++;
    if (vld_ch_log.size() != 4 || vld_ch_log[0] !== 2'd0 || vld_ch_log[3] !== 2'd3) begin
      errors++;
      $display("[TB] FAIL fs_order: %0d results, first %0d expected 4 results from slot 0",
               vld_ch_log.size(), (vld_ch_log.size() > 0) ? vld_ch_log[0] : 2'bxx);
    end
    checks++;
    if ({lft_ld, rght_ld, steer_pot, batt} !== {12'h350, 12'h340, 12'h800, 12'hC00}) begin
      errors++;
      $display("[TB] FAIL fs_regs: got %h %h %h %h expected 350 340 800 c00", lft_ld, rght_ld, steer_pot, batt);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_back_to_back();
    test_timeout();
    test_reset_mid_read();
    test_full_system();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/a2d_sched.md
# a2d_sched

Round-robin conversion scheduler for the external ADC128S A2D converter. It sequences the shared SPI master through the two-transaction ADC128S protocol for four channels: left load cell, right load cell, steering pot and battery. Each trigger performs one channel conversion and stores the 12-bit result in a holding register. It sits between the inertial-interface trigger and the A2D SPI master, feeding the steering-enable, auth and battery-monitor logic.

## Interface
- `CH_LFT`, 3'd0: ADC channel for the left load cell.
- `CH_RGHT`, 3'd4: ADC channel for the right load cell.
- `CH_STEER`, 3'd5: ADC channel for the steering pot.
- `CH_BATT`, 3'd6: ADC channel for the battery.
- `TMO_CYC`, 2048: number of cycles to wait for SPI `done` before aborting a transaction.
- `clk`, in, 1: system clock. Everything is clocked on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `nxt`, in, 1: single-cycle request to convert the next channel in round-robin order.
- `wrt`, out, 1: single-cycle pulse that starts one SPI master transaction.
- `cmd`, out, 16: word for the SPI master to transmit. Value is {2'b00, chnl[2:0], 11'h000}.
- `done`, in, 1: single-cycle pulse from the SPI master marking transaction complete.
- `rd_data`, in, 16: word received by the SPI master. Valid in the cycle `done` is high.
- `lft_ld`, out, 12: latest left load-cell result.
- `rght_ld`, out, 12: latest right load-cell result.
- `steer_pot`, out, 12: latest steering-pot result.
- `batt`, out, 12: latest battery result.
- `vld`, out, 1: single-cycle pulse when a result register has been updated.
- `vld_ch`, out, 2: slot just updated (0 = lft, 1 = rght, 2 = steer, 3 = batt). Meaningful only while `vld` is high.
- `tmo_err`, out, 1: sticky flag set when a timeout abort occurs. Cleared only by `rst`.

## Operation
- Slot pointer `rr` (2 bits) selects the channel in the order lft, rght, steer, batt, then wraps 3 to 0.
- `rr` advances only after a successful capture. A timed-out slot is retried on the next trigger.
- `cmd` always encodes the channel of the current `rr` slot.
- Each conversion uses two SPI transactions, because the ADC128S returns data one frame after the channel address:
  - Transaction 1 sends the channel; its received data is discarded.
  - Transaction 2 resends the same channel; `rd_data[11:0]` is captured from it.
- State machine states:
  - IDLE: when `trig` is set, pulse `wrt` and go to ADDR.
  - ADDR: on `done`, go to GAP.
  - GAP: hold for one cycle so `SS_n` can deassert, pulse `wrt`, go to READ.
  - READ: on `done`, capture `rd_data[11:0]` into the register selected by `rr`, pulse `vld` with `vld_ch = rr`, increment `rr`, go to IDLE.
- `trig` = `nxt` OR `pend`.
- `pend` flag:
  - Set by `nxt` arriving in any state other than IDLE.
  - Cleared when IDLE launches.
  - Multiple triggers while busy collapse into one pending conversion; no queue depth beyond 1.
- `nxt` arriving in IDLE in the same cycle `pend` is set launches exactly one conversion and clears `pend`.
- Timeout:
  - A 12-bit-minimum wait counter clears on each `wrt` and increments in ADDR and READ.
  - If it reaches `TMO_CYC - 1` without `done`: go to IDLE, set `tmo_err`, leave `rr` and all result registers unchanged, no `vld`.
- `done` seen in IDLE or GAP is ignored.
- Reset values: all states return to IDLE; `rr` = 0, `pend` = 0, `wrt` = 0, `vld` = 0, `vld_ch` = 0, `tmo_err` = 0.
- Reset values of result registers:
  - `lft_ld` = 0, `rght_ld` = 0, `steer_pot` = 0.
  - `batt` = 12'hFFF, so low-battery logic does not trip before the first reading.
- `rst` asserted mid-transaction aborts immediately. No further `wrt` pulses until a new trigger after reset.
- `cmd` is registered and stable from the `wrt` cycle until the matching `done`.

## Timing
- `wrt` rises one cycle after the `trig` cycle.
- GAP lasts exactly one cycle: the second `wrt` pulse comes 2 cycles after the first `done`.
- `vld` and the result register update occur one cycle after the second `done`.
- Total latency is 2×T_spi + 4 cycles, where T_spi is the cycle count from a `wrt` pulse to its `done`.
- Back-to-back operation: with `pend` set, the next first `wrt` comes one cycle after `vld`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Round-robin:** SPI model echoes {4'h0, chnl, 9'h0AB}. Pulse `nxt` four times, each after `vld`. Expect:
  - `cmd` channels 0, 4, 5, 6 in order, each sent twice.
  - `vld_ch` 0, 1, 2, 3.
  - Registers hold the data from the second frame only.
- **Wrap:** issue a fifth `nxt`. Expect `rr` back to 0, `cmd` = 16'h0000 and only `lft_ld` updated.
- **Pending collapse:** three `nxt` pulses during ADDR. Expect exactly two conversions total, the second's `wrt` one cycle after the first `vld`.
- **Timeout:** suppress `done` after the first `wrt`. Expect:
  - `tmo_err` = 1 at cycle `TMO_CYC`, state returns to IDLE, no `vld`.
  - Next `nxt` retries the same channel.
- **Reset mid-READ:** assert `rst` for one cycle. Expect:
  - `wrt` = 0, `batt` = 12'hFFF, other registers = 0, `rr` = 0.
  - A stale `done` afterwards causes no `vld`.
- **Full-system:** with the A2D model at ld_cell_lft = 12'h350, ld_cell_rght = 12'h340, steerPot = 12'h800, batt = 12'hC00, all four registers match within one full rotation after reset.
